// File: rtl/operand_issue.sv
// Serial FP32 operand collector for the DP stage-1 operand register.
// Gathers eight words (x1,y1..x4,y4), unpacks them and presents the group in one valid/ready beat.
module operand_issue #(
    parameter int unsigned N_PAIRS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        lp_mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        hi_en,
    output logic        x1_sign, y1_sign, x2_sign, y2_sign,
    output logic        x3_sign, y3_sign, x4_sign, y4_sign,
    output logic [7:0]  x1_exp, y1_exp, x2_exp, y2_exp,
    output logic [7:0]  x3_exp, y3_exp, x4_exp, y4_exp,
    output logic [12:0] x1_high, y1_high, x2_high, y2_high,
    output logic [12:0] x3_high, y3_high, x4_high, y4_high,
    output logic [12:0] x1_low, y1_low, x2_low, y2_low,
    output logic [12:0] x3_low, y3_low, x4_low, y4_low,
    output logic [7:0]  special
);

    localparam int unsigned GROUP  = 2 * N_PAIRS;
    localparam int unsigned CNT_W  = $clog2(GROUP);
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned HALF_W = 13;
    localparam int unsigned MANT_W = 2 * HALF_W;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t                          state_q;
    logic [CNT_W-1:0]                count_q;
    logic                            in_ready_q;
    logic                            out_valid_q;
    logic                            hi_en_q;
    logic [GROUP-1:0]                special_q;
    logic [GROUP-1:0]                sign_q;
    logic [GROUP-1:0][EXP_W-1:0]     exp_q;
    logic [GROUP-1:0][HALF_W-1:0]    high_q;
    logic [GROUP-1:0][HALF_W-1:0]    low_q;

    // Unpack of the incoming word: hidden bit, 23-bit fraction, two guard zeros.
    logic              in_hidden_d;
    logic              in_special_d;
    logic [MANT_W-1:0] in_mant_d;

    assign in_hidden_d  = (in_data[30:23] != 8'h00);
    assign in_special_d = (in_data[30:23] == 8'hFF);
    assign in_mant_d    = {in_hidden_d, in_data[22:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            hi_en_q     <= 1'b0;
            special_q   <= '0;
            sign_q      <= '0;
            exp_q       <= '0;
            high_q      <= '0;
            low_q       <= '0;
        end else if (flush) begin
            // Abort wins over accept/handoff; captured fields are left as they are.
            state_q     <= S_COLLECT;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (in_valid && in_ready_q) begin
                        sign_q[count_q] <= in_data[31];
                        exp_q[count_q]  <= in_data[30:23];
                        low_q[count_q]  <= in_mant_d[HALF_W-1:0];
                        if (!lp_mode) begin
                            high_q[count_q] <= in_mant_d[MANT_W-1:HALF_W];
                        end
                        if (count_q == '0) begin
                            special_q <= {{(GROUP-1){1'b0}}, in_special_d};
                        end else begin
                            special_q[count_q] <= in_special_d;
                        end
                        if (count_q == CNT_W'(GROUP - 1)) begin
                            count_q     <= '0;
                            state_q     <= S_PRESENT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            hi_en_q     <= ~lp_mode;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        state_q     <= S_COLLECT;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign hi_en     = hi_en_q;
    assign special   = special_q;

    // Slot k in issue order maps to x((k/2)+1) for even k, y((k/2)+1) for odd k.
    assign x1_sign = sign_q[0];
    assign y1_sign = sign_q[1];
    assign x2_sign = sign_q[2];
    assign y2_sign = sign_q[3];
    assign x3_sign = sign_q[4];
    assign y3_sign = sign_q[5];
    assign x4_sign = sign_q[6];
    assign y4_sign = sign_q[7];

    assign x1_exp = exp_q[0];
    assign y1_exp = exp_q[1];
    assign x2_exp = exp_q[2];
    assign y2_exp = exp_q[3];
    assign x3_exp = exp_q[4];
    assign y3_exp = exp_q[5];
    assign x4_exp = exp_q[6];
    assign y4_exp = exp_q[7];

    assign x1_high = high_q[0];
    assign y1_high = high_q[1];
    assign x2_high = high_q[2];
    assign y2_high = high_q[3];
    assign x3_high = high_q[4];
    assign y3_high = high_q[5];
    assign x4_high = high_q[6];
    assign y4_high = high_q[7];

    assign x1_low = low_q[0];
    assign y1_low = low_q[1];
    assign x2_low = low_q[2];
    assign y2_low = low_q[3];
    assign x3_low = low_q[4];
    assign y3_low = low_q[5];
    assign x4_low = low_q[6];
    assign y4_low = low_q[7];

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed groups, scoreboard of expected groups checked at each handoff.
module tb_operand_issue;

    logic        clk;
    logic        rst, flush, lp_mode, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, hi_en;
    logic        x1_sign, y1_sign, x2_sign, y2_sign, x3_sign, y3_sign, x4_sign, y4_sign;
    logic [7:0]  x1_exp, y1_exp, x2_exp, y2_exp, x3_exp, y3_exp, x4_exp, y4_exp;
    logic [12:0] x1_high, y1_high, x2_high, y2_high, x3_high, y3_high, x4_high, y4_high;
    logic [12:0] x1_low, y1_low, x2_low, y2_low, x3_low, y3_low, x4_low, y4_low;
    logic [7:0]  special;

    operand_issue #(.N_PAIRS(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .lp_mode(lp_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .hi_en(hi_en),
        .x1_sign(x1_sign), .y1_sign(y1_sign), .x2_sign(x2_sign), .y2_sign(y2_sign),
        .x3_sign(x3_sign), .y3_sign(y3_sign), .x4_sign(x4_sign), .y4_sign(y4_sign),
        .x1_exp(x1_exp), .y1_exp(y1_exp), .x2_exp(x2_exp), .y2_exp(y2_exp),
        .x3_exp(x3_exp), .y3_exp(y3_exp), .x4_exp(x4_exp), .y4_exp(y4_exp),
        .x1_high(x1_high), .y1_high(y1_high), .x2_high(x2_high), .y2_high(y2_high),
        .x3_high(x3_high), .y3_high(y3_high), .x4_high(x4_high), .y4_high(y4_high),
        .x1_low(x1_low), .y1_low(y1_low), .x2_low(x2_low), .y2_low(y2_low),
        .x3_low(x3_low), .y3_low(y3_low), .x4_low(x4_low), .y4_low(y4_low),
        .special(special)
    );

    typedef struct packed {
        logic [7:0]       sign;
        logic [7:0][7:0]  ex;
        logic [7:0][12:0] high;
        logic [7:0][12:0] low;
        logic [7:0]       special;
        logic             hi_en;
    } grp_t;

    logic [7:0]       d_sign;
    logic [7:0][7:0]  d_exp;
    logic [7:0][12:0] d_high, d_low;
    grp_t             cur;
    logic [290:0]     d_all;

    assign d_sign = {y4_sign, x4_sign, y3_sign, x3_sign, y2_sign, x2_sign, y1_sign, x1_sign};
    assign d_exp  = {y4_exp, x4_exp, y3_exp, x3_exp, y2_exp, x2_exp, y1_exp, x1_exp};
    assign d_high = {y4_high, x4_high, y3_high, x3_high, y2_high, x2_high, y1_high, x1_high};
    assign d_low  = {y4_low, x4_low, y3_low, x3_low, y2_low, x2_low, y1_low, x1_low};
    assign cur    = {d_sign, d_exp, d_high, d_low, special, hi_en};
    assign d_all  = {cur, out_valid, in_ready};

    grp_t sb_q[$];
    grp_t model;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Expected field update for one accepted word, straight from the unpack rules.
    task automatic model_accept(input int slot, input logic [31:0] w, input logic lp);
        logic [25:0] mant;
        mant = {(w[30:23] != 8'h00), w[22:0], 2'b00};
        model.sign[slot] = w[31];
        model.ex[slot]   = w[30:23];
        model.low[slot]  = mant[12:0];
        if (!lp) model.high[slot] = mant[25:13];
        if (slot == 0) model.special = 8'h00;
        model.special[slot] = (w[30:23] == 8'hFF);
    endtask

    task automatic send_word(input logic [31:0] w, input logic lp, input int slot, input bit push);
        in_valid = 1'b1;
        in_data  = w;
        lp_mode  = lp;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(slot, w, lp);
        if (slot == 7) begin
            model.hi_en = ~lp;
            if (push) sb_q.push_back(model);
        end
    endtask

    task automatic send_group(input logic [7:0][31:0] words, input logic [7:0] lps, input bit push);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("latency_pre", 32'(out_valid), 32'd0);
            send_word(words[k], lps[k], k, push);
        end
        chk("latency_post", 32'(out_valid), 32'd1);
        chk("present_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic handoff(input int nwait);
        logic [290:0] snap;
        snap = d_all;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_stable", 32'(d_all == snap), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Scoreboard monitor: compare every group stage 1 actually captures.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_group", 32'(sb_q.size()), 32'd1);
            end else begin
                grp_t e;
                e = sb_q.pop_front();
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("sign%0d", k), 32'(d_sign[k]), 32'(e.sign[k]));
                    chk($sformatf("exp%0d", k), 32'(d_exp[k]), 32'(e.ex[k]));
                    chk($sformatf("high%0d", k), 32'(d_high[k]), 32'(e.high[k]));
                    chk($sformatf("low%0d", k), 32'(d_low[k]), 32'(e.low[k]));
                end
                chk("special", 32'(special), 32'(e.special));
                chk("hi_en", 32'(hi_en), 32'(e.hi_en));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0][31:0] g;
        rst = 1'b1; flush = 1'b0; lp_mode = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = 32'h0;
        model = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hi_en", 32'(hi_en), 32'd0);
        chk("rst_fields_zero", 32'(cur == '0), 32'd1);

        // All-1.5 group, full precision
        for (int k = 0; k < 8; k++) g[k] = 32'h3FC00000;
        send_group(g, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t2_exp", 32'(d_exp[k]), 32'h7F);
            chk("t2_high", 32'(d_high[k]), 32'h1800);
            chk("t2_low", 32'(d_low[k]), 32'h0);
        end
        chk("t2_hi_en", 32'(hi_en), 32'd1);
        handoff(0);

        // Reduced-precision group: high halves retained
        for (int k = 0; k < 8; k++) g[k] = 32'hC0200FFF;
        send_group(g, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) chk("t5_high_kept", 32'(d_high[k]), 32'h1800);
        chk("t5_x1_low", 32'(x1_low), 32'h1FFC);
        chk("t5_x1_exp", 32'(x1_exp), 32'h80);
        chk("t5_y4_sign", 32'(y4_sign), 32'd1);
        chk("t5_hi_en", 32'(hi_en), 32'd0);
        handoff(0);

        // Denormal, specials and backpressure
        g[0] = 32'h00000001; g[1] = 32'hBF800000; g[2] = 32'h40490FDB; g[3] = 32'h3FC00000;
        g[4] = 32'hC0200FFF; g[5] = 32'h00000000; g[6] = 32'h41200000; g[7] = 32'h7F800000;
        send_group(g, 8'h00, 1'b1);
        chk("t3_x1_exp", 32'(x1_exp), 32'h0);
        chk("t3_x1_high", 32'(x1_high), 32'h0);
        chk("t3_x1_low", 32'(x1_low), 32'h0004);
        chk("t3_y4_high", 32'(y4_high), 32'h1000);
        chk("t3_special", 32'(special), 32'h80);
        handoff(5);

        // lp_mode toggling per slot; slot 7 full precision sets hi_en
        for (int k = 0; k < 8; k++) g[k] = 32'h40490FDB;
        send_group(g, 8'b0101_0101, 1'b1);
        handoff(1);

        // Flush after 5 accepts, with a word offered in the flush cycle
        for (int k = 0; k < 5; k++) send_word(32'h3F800000, 1'b0, k, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h7F800000;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) g[k] = 32'h40000000 + (32'(k) << 20);
        send_group(g, 8'h00, 1'b1);
        handoff(0);

        // Flush together with out_ready while presenting
        for (int k = 0; k < 8; k++) g[k] = 32'hC1000000 - (32'(k) << 19);
        g[3] = 32'hFF800000;
        send_group(g, 8'h00, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flushp_out_valid", 32'(out_valid), 32'd0);
        chk("flushp_in_ready", 32'(in_ready), 32'd1);
        chk("flushp_fields_hold", 32'(cur == model), 32'd1);
        for (int k = 0; k < 8; k++) g[k] = 32'h3E000001 + 32'(k);
        send_group(g, 8'h00, 1'b1);
        handoff(2);

        // Reset mid-group discards partial data
        for (int k = 0; k < 3; k++) send_word(32'h42F60000, 1'b0, k, 1'b0);
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        model = '0;
        chk("rst2_fields_zero", 32'(cur == '0), 32'd1);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) g[k] = 32'hBFC00000;
        send_group(g, 8'h00, 1'b1);
        handoff(0);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
